// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared encodings and default widths for the IFU/LSU memory
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int unsigned ARB_AW_DEF = 32;
    localparam int unsigned ARB_DW_DEF = 32;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_REQ  = ARB_REQ,
        ST_RESP = ARB_RESP
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of IFU, LSU and memory-side handshake signals around
//               the arbiter. slave = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW_DEF,
    parameter int DW = ARB_DW_DEF
) ();

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [AW-1:0]     ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DW-1:0]     ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [AW-1:0]     lsu_addr;
    logic              lsu_wen;
    logic [DW-1:0]     lsu_wdata;
    logic [DW/8-1:0]   lsu_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DW-1:0]     lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_addr;
    logic              mem_wen;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wmask;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DW-1:0]     mem_rdata;

    logic              busy;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
        output busy
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
        input  busy
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational grant picker. A grant means "this side may fire
//               if it is valid". MEM_ARB_RR_EN selects round-robin on ties,
//               otherwise the LSU always wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_ifu_valid,
    input  logic i_lsu_valid,
    input  logic i_last_owner,
    output logic grant_ifu,
    output logic grant_lsu
);

`ifdef MEM_ARB_RR_EN
    // A side is held off only when the other side is requesting and won less recently.
    assign grant_ifu = !i_lsu_valid || (i_last_owner == OWN_LSU);
    assign grant_lsu = !i_ifu_valid || (i_last_owner == OWN_IFU);
`else
    logic w_unused;

    assign grant_lsu = 1'b1;
    assign grant_ifu = !i_lsu_valid;
    assign w_unused  = i_ifu_valid ^ i_last_owner;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between IFU (read-only) and LSU; the
//               grant is held from request acceptance to response handoff.
//               Define MEM_ARB_RR_EN for round-robin tie-breaking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW_DEF,
    parameter int DW = ARB_DW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic              r_owner;
    logic [AW-1:0]     r_addr;
    logic              r_wen;
    logic [DW-1:0]     r_wdata;
    logic [DW/8-1:0]   r_wmask;

    logic w_last_owner;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_ifu_req_ready;
    logic w_lsu_req_ready;
    logic w_ifu_fire;
    logic w_lsu_fire;
    logic w_mem_req_valid;
    logic w_mem_resp_ready;
    logic w_ifu_resp_valid;
    logic w_lsu_resp_valid;

`ifdef MEM_ARB_RR_EN
    logic r_last_owner;

    // Starts at LSU so that the IFU wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWN_LSU;
        end else if (w_lsu_fire) begin
            r_last_owner <= OWN_LSU;
        end else if (w_ifu_fire) begin
            r_last_owner <= OWN_IFU;
        end
    end

    assign w_last_owner = r_last_owner;
`else
    assign w_last_owner = OWN_LSU;
`endif

    mem_arb_pick u_pick (
        .i_ifu_valid  (bus.ifu_req_valid),
        .i_lsu_valid  (bus.lsu_req_valid),
        .i_last_owner (w_last_owner),
        .grant_ifu    (w_grant_ifu),
        .grant_lsu    (w_grant_lsu)
    );

    assign w_ifu_fire = bus.ifu_req_valid && w_ifu_req_ready;
    assign w_lsu_fire = bus.lsu_req_valid && w_lsu_req_ready;

    // Every handshake output is forced low while rst is high, whatever the state.
    always_comb begin
        w_next_state     = r_state;
        w_ifu_req_ready  = 1'b0;
        w_lsu_req_ready  = 1'b0;
        w_mem_req_valid  = 1'b0;
        w_mem_resp_ready = 1'b0;
        w_ifu_resp_valid = 1'b0;
        w_lsu_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ifu_req_ready = !rst && w_grant_ifu;
                w_lsu_req_ready = !rst && w_grant_lsu;
                if ((bus.ifu_req_valid && w_ifu_req_ready) ||
                    (bus.lsu_req_valid && w_lsu_req_ready)) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                w_mem_req_valid = !rst;
                if (bus.mem_req_ready) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_mem_resp_ready = !rst && ((r_owner == OWN_LSU) ? bus.lsu_resp_ready
                                                                 : bus.ifu_resp_ready);
                w_ifu_resp_valid = !rst && (r_owner == OWN_IFU) && bus.mem_resp_valid;
                w_lsu_resp_valid = !rst && (r_owner == OWN_LSU) && bus.mem_resp_valid;
                if (bus.mem_resp_valid && w_mem_resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_lsu_fire) begin
                r_owner <= OWN_LSU;
                r_addr  <= bus.lsu_addr;
                r_wen   <= bus.lsu_wen;
                r_wdata <= bus.lsu_wdata;
                r_wmask <= bus.lsu_wmask;
            end else if (w_ifu_fire) begin
                r_owner <= OWN_IFU;
                r_addr  <= bus.ifu_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end
        end
    end

    assign bus.ifu_req_ready  = w_ifu_req_ready;
    assign bus.lsu_req_ready  = w_lsu_req_ready;
    assign bus.mem_req_valid  = w_mem_req_valid;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wen        = r_wen;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wmask      = r_wmask;
    assign bus.mem_resp_ready = w_mem_resp_ready;
    assign bus.ifu_resp_valid = w_ifu_resp_valid;
    assign bus.lsu_resp_valid = w_lsu_resp_valid;
    assign bus.ifu_rdata      = bus.mem_rdata;
    assign bus.lsu_rdata      = bus.mem_rdata;
    assign bus.busy           = !rst && (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus
//               random traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: phase 0 = no transaction, 1 = waiting for memory accept,
    // 2 = waiting for the response to be handed to the owner.
    int          m_phase = 0;
    bit          m_owner = OWN_IFU;
    bit          m_last  = OWN_LSU;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    bit          m_wen   = 1'b0;
    logic [3:0]  m_wmask = '0;
    int          m_fire_cyc = 0;
    int          m_lat = -1;
    bit          m_ifu_fired = 1'b0;
    bit          m_lsu_fired = 1'b0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, return 1 after the rising edge.
    task automatic cycle();
        logic [6:0] e;
        logic [6:0] a;
        bit tie_lsu, ir, lr, own_rdy;
        bit ifire, lfire, rfire;
        ifire = 1'b0; lfire = 1'b0; rfire = 1'b0;
        @(negedge clk);
        e = '0;
        if (!rst) begin
            case (m_phase)
                0: begin
                    tie_lsu = c_rr ? (m_last == OWN_IFU) : 1'b1;
                    ir = !(bus.lsu_req_valid && tie_lsu);
                    lr = !(bus.ifu_req_valid && !tie_lsu);
                    e[6] = ir;
                    e[5] = lr;
                    ifire = bus.ifu_req_valid && ir;
                    lfire = bus.lsu_req_valid && lr;
                end
                1: begin
                    e[4] = 1'b1;
                    e[0] = 1'b1;
                end
                default: begin
                    own_rdy = m_owner ? bus.lsu_resp_ready : bus.ifu_resp_ready;
                    e[3] = own_rdy;
                    e[2] = !m_owner && bus.mem_resp_valid;
                    e[1] = m_owner && bus.mem_resp_valid;
                    e[0] = 1'b1;
                    rfire = bus.mem_resp_valid && own_rdy;
                end
            endcase
        end
        a = {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.mem_resp_ready,
             bus.ifu_resp_valid, bus.lsu_resp_valid, bus.busy};
        check($sformatf("ctl@%0d", cyc), a, e);
        if (!rst && m_phase == 1)
            check($sformatf("mem_req@%0d", cyc),
                  {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask},
                  {m_addr, m_wen, m_wdata, m_wmask});
        if (e[2]) check($sformatf("ifu_rdata@%0d", cyc), bus.ifu_rdata, bus.mem_rdata);
        if (e[1]) check($sformatf("lsu_rdata@%0d", cyc), bus.lsu_rdata, bus.mem_rdata);

        m_ifu_fired = ifire;
        m_lsu_fired = lfire;
        if (rst) begin
            m_phase = 0; m_owner = OWN_IFU; m_last = OWN_LSU;
            m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        end else if (m_phase == 0) begin
            if (lfire) begin
                m_owner = OWN_LSU; m_addr = bus.lsu_addr; m_wen = bus.lsu_wen;
                m_wdata = bus.lsu_wdata; m_wmask = bus.lsu_wmask;
            end else if (ifire) begin
                m_owner = OWN_IFU; m_addr = bus.ifu_addr; m_wen = 1'b0;
                m_wdata = '0; m_wmask = '0;
            end
            if (lfire || ifire) begin
                m_phase = 1; m_last = m_owner; m_fire_cyc = cyc;
            end
        end else if (m_phase == 1) begin
            if (bus.mem_req_ready) m_phase = 2;
        end else if (rfire) begin
            m_phase = 0;
            m_lat = cyc - m_fire_cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input string tag);
        int b = 0;
        while (m_phase != 0 && b < 40) begin
            cycle();
            b++;
        end
        if (m_phase != 0) check({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    // Present the current requests until one is granted, confirm the DUT latched exp_addr.
    task automatic tie_round(input string tag, input logic [31:0] exp_addr, input bit drop_all);
        int b = 0;
        m_ifu_fired = 1'b0;
        m_lsu_fired = 1'b0;
        while (!(m_ifu_fired || m_lsu_fired) && b < 20) begin
            cycle();
            b++;
        end
        if (!(m_ifu_fired || m_lsu_fired)) begin
            check({tag, "_timeout"}, 128'd0, 128'd1);
        end else begin
            check({tag, "_grant"}, bus.mem_addr, exp_addr);
        end
        if (m_ifu_fired || drop_all) bus.ifu_req_valid = 1'b0;
        if (m_lsu_fired || drop_all) bus.lsu_req_valid = 1'b0;
        wait_idle(tag);
    endtask

    task automatic rand_drive();
        if (bus.ifu_req_valid && !m_ifu_fired) begin
            if ($urandom_range(19) == 0) bus.ifu_req_valid = 1'b0;
        end else begin
            bus.ifu_req_valid = ($urandom_range(2) == 0);
            bus.ifu_addr      = $urandom() & 32'hFFFF_FFFC;
        end
        if (bus.lsu_req_valid && !m_lsu_fired) begin
            if ($urandom_range(19) == 0) bus.lsu_req_valid = 1'b0;
        end else begin
            bus.lsu_req_valid = ($urandom_range(2) == 0);
            bus.lsu_addr      = $urandom();
            bus.lsu_wen       = $urandom_range(1);
            bus.lsu_wdata     = $urandom();
            bus.lsu_wmask     = 4'($urandom_range(15));
        end
        bus.ifu_resp_ready = ($urandom_range(3) != 0);
        bus.lsu_resp_ready = ($urandom_range(3) != 0);
        bus.mem_req_ready  = ($urandom_range(2) != 0);
        bus.mem_resp_valid = ($urandom_range(2) != 0);
        bus.mem_rdata      = $urandom();
        rst                = ($urandom_range(299) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0; bus.ifu_resp_ready = 1'b0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = '0; bus.lsu_wmask = '0; bus.lsu_resp_ready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = '0;

        // Reset, with a stray memory response that must be ignored.
        repeat (3) cycle();
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        bus.mem_resp_valid = 1'b0;
        #1;
        check("post_rst_addr", {bus.mem_addr, bus.mem_wen, bus.mem_wmask}, 37'd0);
        check("post_rst_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b11);

        // IFU only, zero-wait memory.
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0000; bus.ifu_resp_ready = 1'b1;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h0000_0413;
        cycle();
        bus.ifu_req_valid = 1'b0;
        check("ifu_req_fields", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask},
              {1'b1, 32'h8000_0000, 1'b0, 4'h0});
        check("ifu_busy_req", bus.busy, 1'b1);
        cycle();
        check("ifu_resp", {bus.ifu_resp_valid, bus.ifu_rdata, bus.busy}, {1'b1, 32'h0000_0413, 1'b1});
        cycle();
        check("ifu_latency", m_lat, 2);
        check("ifu_busy_done", bus.busy, 1'b0);

        // LSU store.
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1'b1;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'b0011; bus.lsu_resp_ready = 1'b1;
        cycle();
        bus.lsu_req_valid = 1'b0;
        check("lsu_store_fields", {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask},
              {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011});
        cycle();
        check("lsu_store_resp", {bus.lsu_resp_valid, bus.ifu_resp_valid}, 2'b10);
        cycle();

        // Simultaneous requests.
        bus.ifu_addr = 32'h8000_0100;
        bus.lsu_addr = 32'h8000_0200; bus.lsu_wen = 1'b0; bus.lsu_wmask = 4'h0;
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            bus.ifu_req_valid = 1'b1;
            bus.lsu_req_valid = 1'b1;
            #1;
            check($sformatf("rr_tie_ready%0d", k), {bus.ifu_req_ready, bus.lsu_req_ready},
                  (k % 2 == 0) ? 2'b10 : 2'b01);
            tie_round($sformatf("rr_tie%0d", k), (k % 2 == 0) ? 32'h8000_0100 : 32'h8000_0200, 1'b1);
        end
`else
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        #1;
        check("fix_tie_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
        tie_round("fix_tie_first", 32'h8000_0200, 1'b0);
        tie_round("fix_tie_second", 32'h8000_0100, 1'b0);
`endif

        // Backpressure on both memory channels, LSU waiting behind.
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_2000; bus.ifu_resp_ready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        cycle();
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_3000; bus.lsu_wen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_req_hold", {bus.mem_req_valid, bus.mem_addr, bus.lsu_req_ready},
                  {1'b1, 32'h8000_2000, 1'b0});
        end
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("bp_resp_hold", {bus.mem_resp_ready, bus.lsu_req_ready, bus.busy}, 3'b001);
            cycle();
        end
        bus.ifu_resp_ready = 1'b1;
        #1;
        check("bp_resp_go", {bus.mem_resp_ready, bus.ifu_resp_valid, bus.ifu_rdata},
              {2'b11, 32'hCAFE_F00D});
        cycle();
        tie_round("bp_lsu_after", 32'h8000_3000, 1'b0);

        // Reset while an LSU response is pending.
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_4000; bus.mem_resp_valid = 1'b0;
        cycle();
        bus.lsu_req_valid = 1'b0;
        cycle();
        check("rst_resp_pending", bus.busy, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        #1;
        check("rst_resp_abort", {bus.busy, bus.lsu_resp_valid, bus.mem_resp_ready}, 3'b000);
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_5000;
        cycle();
        bus.ifu_req_valid = 1'b0;
        cycle();
        check("rst_then_ifu", {bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid},
              {1'b1, 32'h1234_5678, 1'b0});
        cycle();

        // Random traffic, including stray responses, early withdrawals and resets.
        for (int k = 0; k < 2000; k++) begin
            rand_drive();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
